deser_4bit: RTL and testbench
=============================

DESER_4BIT -- requirements
Module: deser_4bit

Interface
REQ-001 Parameter: PwrC, default 0, index of this instance's transition counter; it has no functional effect on the ports.
REQ-002 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 Port: S_IN  input  1  serial data bit.
REQ-005 Port: S_VALID  input  1  S_IN carries a valid bit this cycle.
REQ-006 Port: DIR  input  1  bit order; 0 = MSB first, 1 = LSB first; sampled when the first bit of a word is accepted.
REQ-007 Port: Q  output  4  last completed parallel word.
REQ-008 Port: Q_VALID  output  1  Q holds an unconsumed word.
REQ-009 Port: Q_ACK  input  1  consumer takes Q; it is meaningful only while Q_VALID = 1.
REQ-010 Port: BIT_CNT  output  2  number of bits of the current word accepted so far (0..3).
REQ-011 Port: OVR  output  1  sticky overrun flag.

Function
REQ-012 The block SHALL be the receiving end of the 4-bit shift register serial output: it collects 4 serial bits into one parallel word.
REQ-013 State machine SHALL have three states: IDLE (BIT_CNT = 0, no partial word), SHIFT (1 to 3 bits held), FULL_WAIT (word complete, hold register occupied).
REQ-014 A bit SHALL be accepted on a rising edge where S_VALID = 1; S_VALID = 0 leaves the shift register and BIT_CNT unchanged.
REQ-015 The order latch SHALL capture DIR on acceptance of bit 0 of a word; DIR changes mid-word SHALL NOT affect that word.
REQ-016 When order = 0, the shift register SHALL shift left with S_IN entering bit 0, so the first bit ends in Q[3].
REQ-017 When order = 1, the shift register SHALL shift right with S_IN entering bit 3, so the first bit ends in Q[0].
REQ-018 BIT_CNT SHALL increment on each accepted bit and wrap from 3 to 0 on the 4th bit.
REQ-019 On the 4th accepted bit, the assembled word (including that bit) SHALL be copied into the hold register Q, with Q_VALID = 1 from the next cycle.
REQ-020 Latency SHALL be 1 cycle from the edge accepting the 4th bit to Q/Q_VALID being visible.
REQ-021 Q and Q_VALID SHALL remain stable until an edge where Q_VALID = 1 and Q_ACK = 1; after that edge Q_VALID = 0 and Q holds its last value.
REQ-022 Q_ACK while Q_VALID = 0 SHALL be ignored.
REQ-023 Reception SHALL continue while Q_VALID = 1; the next word's bits shift normally.
REQ-024 If a 4th bit completes while Q_VALID = 1 and Q_ACK = 0 on that edge: Q SHALL be overwritten with the new word, Q_VALID SHALL stay 1, and OVR SHALL be set to 1.
REQ-025 If a 4th bit completes on the same edge as a valid Q_ACK: the new word SHALL load, Q_VALID SHALL stay 1, and OVR SHALL NOT be set.
REQ-026 OVR SHALL stay 1 until reset.
REQ-027 Transitions: IDLE->SHIFT on an accepted bit; SHIFT->SHIFT on bits 2 and 3; SHIFT->FULL_WAIT on bit 4; FULL_WAIT->IDLE on ack with no new bit; FULL_WAIT->SHIFT on an accepted bit, whether or not an ack occurs on that edge.
REQ-028 The FSM state is derived from BIT_CNT and Q_VALID; FULL_WAIT is the condition Q_VALID = 1 with BIT_CNT = 0.
REQ-029 All outputs SHALL be registered; no combinational path from an input to an output.

Reset
REQ-030 On a rising edge with RESET = 1: Q = 4'b0000, Q_VALID = 0, BIT_CNT = 0, OVR = 0, shift register = 0, order latch = 0, state = IDLE.
REQ-031 RESET SHALL take priority over S_VALID and Q_ACK on the same edge.
REQ-032 Reset mid-word SHALL discard the partial word; the next accepted bit is bit 0 of a new word.

Verification
REQ-033 Reset, DIR = 0, bits 1,0,1,1 on 4 consecutive cycles -> BIT_CNT 1,2,3,0; Q = 4'b1011 with Q_VALID = 1 one cycle after the 4th bit.
REQ-034 DIR = 1, bits 1,0,1,1, with DIR toggled after bit 0 -> Q = 4'b1101; the toggle has no effect.
REQ-035 Gaps: bits 0,1,1,0 with S_VALID = 0 cycles between them -> Q = 4'b0110; BIT_CNT holds during the gaps.
REQ-036 Word A = 4'b1010 not acked, then word B = 4'b0101 received -> Q = 4'b0101, Q_VALID = 1, OVR = 1.
REQ-037 Q_ACK asserted on the same edge as B's 4th bit -> Q = 4'b0101, Q_VALID = 1, OVR = 0.
REQ-038 RESET asserted after 2 bits -> all outputs 0; 4 new bits 1,1,1,1 -> Q = 4'b1111.

Source files
------------

// File: rtl/deser_4bit.sv
// deser_4bit: 4-bit serial-to-parallel receiver with a one-deep hold register.
// Ports:
//   CLK, RESET   clock and synchronous active-high reset
//   S_IN/S_VALID serial bit and its qualifier
//   DIR          bit order (0 = MSB first, 1 = LSB first), latched at bit 0
//   Q/Q_VALID    completed word and its occupancy flag; Q_ACK consumes it
//   BIT_CNT      bits of the current word accepted so far
//   OVR          sticky overrun (unconsumed word overwritten)
module deser_4bit #(
   parameter int PwrC = 0
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       S_IN,
   input  logic       S_VALID,
   input  logic       DIR,
   output logic [3:0] Q,
   output logic       Q_VALID,
   input  logic       Q_ACK,
   output logic [1:0] BIT_CNT,
   output logic       OVR
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT     = 2'd1,
      FULL_WAIT = 2'd2
   } state_t;

   // PwrC only tags the instance for external activity accounting;
   // any non-negative index elaborates the same receiver.
   if (PwrC >= 0) begin : g_core

      state_t     state_q, state_d;
      logic [3:0] sr_q, sr_d;
      logic [1:0] cnt_q, cnt_d;
      logic       order_q, order_d;
      logic [3:0] hold_q, hold_d;
      logic       qv_q, qv_d;
      logic       ovr_q, ovr_d;

      logic       first_bit;
      logic       last_bit;
      logic       ack;
      logic       order_eff;
      logic [3:0] shifted;

      // Datapath helpers
      always_comb begin
         first_bit = S_VALID && (cnt_q == 2'd0);
         last_bit  = S_VALID && (cnt_q == 2'd3);
         ack       = qv_q && Q_ACK;
         // Bit 0 uses the live DIR so the whole word shares one order.
         order_eff = first_bit ? DIR : order_q;
         if (order_eff) begin
            shifted = {S_IN, sr_q[3:1]};
         end else begin
            shifted = {sr_q[2:0], S_IN};
         end
      end

      // Shift register, bit counter and order latch
      always_comb begin
         sr_d    = sr_q;
         cnt_d   = cnt_q;
         order_d = order_q;
         if (S_VALID) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 2'd1;
            if (first_bit) begin
               order_d = DIR;
            end
         end
      end

      // Hold register, occupancy and overrun
      always_comb begin
         hold_d = hold_q;
         qv_d   = qv_q;
         ovr_d  = ovr_q;
         if (last_bit) begin
            hold_d = shifted;
            qv_d   = 1'b1;
            // Overwriting a word nobody took this edge is an overrun.
            if (qv_q && !Q_ACK) begin
               ovr_d = 1'b1;
            end
         end else if (ack) begin
            qv_d = 1'b0;
         end
      end

      // FSM next state
      always_comb begin
         state_d = state_q;
         unique case (state_q)
            IDLE: begin
               if (S_VALID) begin
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (last_bit) begin
                  state_d = FULL_WAIT;
               end else if (cnt_q == 2'd0) begin
                  // Word done while reception continued, then consumed.
                  state_d = qv_d ? FULL_WAIT : IDLE;
               end
            end
            FULL_WAIT: begin
               if (S_VALID) begin
                  state_d = SHIFT;
               end else if (ack) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      always_ff @(posedge CLK) begin
         if (RESET) begin
            state_q <= IDLE;
            sr_q    <= 4'b0000;
            cnt_q   <= 2'd0;
            order_q <= 1'b0;
            hold_q  <= 4'b0000;
            qv_q    <= 1'b0;
            ovr_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            hold_q  <= hold_d;
            qv_q    <= qv_d;
            ovr_q   <= ovr_d;
         end
      end

      assign Q       = hold_q;
      assign Q_VALID = qv_q;
      assign BIT_CNT = cnt_q;
      assign OVR     = ovr_q;

   end

endmodule

// File: tb/tb_deser_4bit.sv
// tb_deser_4bit: scoreboard bench for deser_4bit.
// Expected words are queued as bits are driven and compared on completion.
module tb_deser_4bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_in;
   logic       s_valid;
   logic       dir;
   logic [3:0] q;
   logic       q_valid;
   logic       q_ack;
   logic [1:0] bit_cnt;
   logic       ovr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] q;
      logic       ovr;
   } exp_t;

   exp_t sb[$];
   logic qv_m;
   logic ovr_m;
   logic [3:0] q_m;

   always #5 clk = ~clk;

   deser_4bit #(.PwrC(0)) dut (
      .CLK    (clk),
      .RESET  (rst),
      .S_IN   (s_in),
      .S_VALID(s_valid),
      .DIR    (dir),
      .Q      (q),
      .Q_VALID(q_valid),
      .Q_ACK  (q_ack),
      .BIT_CNT(bit_cnt),
      .OVR    (ovr)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag);
      chk({tag, ".q"}, {4'd0, q}, {4'd0, q_m});
      chk({tag, ".qv"}, {7'd0, q_valid}, {7'd0, qv_m});
      chk({tag, ".ovr"}, {7'd0, ovr}, {7'd0, ovr_m});
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      s_valid = 1'b1;
      s_in = 1'b1;
      q_ack = 1'b1;
      tick();
      rst = 1'b0;
      s_valid = 1'b0;
      q_ack = 1'b0;
      qv_m = 1'b0;
      ovr_m = 1'b0;
      q_m = 4'b0000;
      sb.delete();
      chk_out(tag);
      chk({tag, ".cnt"}, {6'd0, bit_cnt}, 8'd0);
   endtask

   // bits[3] is sent first
   task automatic send_word(input string tag, input logic [3:0] bits,
                            input logic d, input bit tog,
                            input int gap, input bit ack_last);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         s_in = bits[3-i];
         s_valid = 1'b1;
         dir = (i > 0 && tog) ? ~d : d;
         q_ack = (i == 3) && ack_last;
         if (i == 3) begin
            e.q = d ? {bits[0], bits[1], bits[2], bits[3]} : bits;
            e.ovr = ovr_m | (qv_m & ~ack_last);
            sb.push_back(e);
         end
         tick();
         s_valid = 1'b0;
         q_ack = 1'b0;
         chk({tag, ".cnt"}, {6'd0, bit_cnt}, 8'((i + 1) % 4));
         for (int g = 0; g < gap && i < 3; g++) begin
            s_in = ~s_in;
            dir = ~dir;
            tick();
            chk({tag, ".gap"}, {6'd0, bit_cnt}, 8'(i + 1));
         end
      end
      if (sb.size() == 0) begin
         chk({tag, ".sb"}, 8'd0, 8'd1);
      end else begin
         e = sb.pop_front();
         q_m = e.q;
         qv_m = 1'b1;
         ovr_m = e.ovr;
         chk_out(tag);
      end
   endtask

   task automatic do_ack(input string tag);
      q_ack = 1'b1;
      tick();
      q_ack = 1'b0;
      qv_m = 1'b0;
      chk_out(tag);
   endtask

   initial begin
      logic [3:0] w;
      logic d;
      rst = 1'b0;
      s_in = 1'b0;
      s_valid = 1'b0;
      dir = 1'b0;
      q_ack = 1'b0;
      qv_m = 1'b0;
      ovr_m = 1'b0;
      q_m = 4'b0000;
      tick();
      do_reset("rst0");

      send_word("msb", 4'b1011, 1'b0, 1'b0, 0, 1'b0);
      tick();
      tick();
      chk_out("hold");
      do_ack("ack1");
      do_ack("ack_idle");

      send_word("lsb", 4'b1011, 1'b1, 1'b1, 0, 1'b0);
      do_ack("ack2");

      send_word("gap", 4'b0110, 1'b0, 1'b0, 2, 1'b0);
      do_ack("ack3");

      send_word("wa", 4'b1010, 1'b0, 1'b0, 0, 1'b0);
      send_word("wb_ovr", 4'b0101, 1'b0, 1'b0, 0, 1'b0);
      send_word("ovr_sticky", 4'b1100, 1'b0, 1'b0, 0, 1'b1);
      do_ack("ack4");

      do_reset("rst1");
      send_word("wa2", 4'b1010, 1'b0, 1'b0, 0, 1'b0);
      send_word("wb_ack", 4'b0101, 1'b0, 1'b0, 0, 1'b1);
      do_ack("ack5");

      s_valid = 1'b1;
      s_in = 1'b0;
      tick();
      tick();
      s_valid = 1'b0;
      chk("mid.cnt", {6'd0, bit_cnt}, 8'd2);
      do_reset("rst_mid");
      send_word("ones", 4'b1111, 1'b0, 1'b0, 0, 1'b0);
      do_ack("ack6");

      for (int k = 0; k < 8; k++) begin
         w = 4'($urandom_range(0, 15));
         d = 1'($urandom_range(0, 1));
         send_word("rnd", w, d, 1'b1, k % 3, 1'b0);
         if (k % 2 == 1) begin
            do_ack("rnd_ack");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
